// File: rtl/acc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acc_ctrl_pkg
// Shared definitions for the accelerator launch controller slice.
//   - State encoding constants and the typed FSM state enum.
//   - Default progress-counter width and the in-flight counter width.
//   - wdog_width(): counter width needed to reach a given watchdog limit.
// -----------------------------------------------------------------------------
package acc_ctrl_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    // Launches in flight are tracked in 8 bits (MAX_OUTSTANDING <= 255).
    localparam int unsigned OUT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StErr  = ST_ERR
    } ctrl_state_e;

    // Width that can hold the value 'limit'; never below one bit so a disabled
    // watchdog (limit 0) still yields a legal vector.
    function automatic int unsigned wdog_width(input int unsigned limit);
        if (limit < 2) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/acc_wdog_cnt.sv
// -----------------------------------------------------------------------------
// acc_wdog_cnt
// Loadable timeout counter. Counts up while enabled and flags expiry on the
// cycle whose increment would make the count reach LIMIT, so a consumer that
// acts on 'expired' at that edge changes state exactly LIMIT counting cycles
// after the last clear. LIMIT = 0 disables expiry.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   clr       synchronous clear to zero (highest priority)
//   load      synchronous load of load_val
//   load_val  value taken on load
//   en        count enable
//   expired   expiry flag (combinational from count, en, clr, load)
// -----------------------------------------------------------------------------
module acc_wdog_cnt #(
    parameter int unsigned LIMIT = 1048576,
    parameter int unsigned W     = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    // Count value seen on the edge at which the limit is reached.
    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);
    localparam logic         ENABLED = (LIMIT != 0);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    always_comb begin
        expired = ENABLED && en && !clr && !load && (count_q == LAST);
    end

endmodule

// File: rtl/acc_launch_ctrl.sv
// -----------------------------------------------------------------------------
// acc_launch_ctrl
// Initiator side of the ap_ctrl_chain handshake. Accepts a "launch N times"
// command, issues the launches with at most MAX_OUTSTANDING in flight,
// acknowledges every completion and reports progress. A watchdog moves the
// controller to an error state when pending work sees no handshake for
// TIMEOUT_CYCLES cycles; err_clear returns it to idle.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cmd_valid/ready/runs   launch command (accepted on valid && ready)
//   err_clear      leaves the error state
//   ap_start/ap_ready      launch handshake to the engine
//   ap_done/ap_continue    completion handshake with the engine
//   ap_idle        engine idle status (informational only)
//   busy           controller not idle
//   launched_cnt   launches accepted in the current command
//   done_cnt       completions acknowledged in the current command
//   run_complete   one-cycle pulse on command completion
//   timeout_err    high while in the error state
// All outputs are registers.
// -----------------------------------------------------------------------------
module acc_launch_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W           = CNT_W_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_runs,
    input  logic             err_clear,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    input  logic             ap_idle,
    output logic             busy,
    output logic [CNT_W-1:0] launched_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             run_complete,
    output logic             timeout_err
);

    localparam int unsigned      WDOG_W  = wdog_width(TIMEOUT_CYCLES);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] launched_d, done_d;
    logic             run_complete_d;
    logic             ap_start_d;
    logic             ap_continue_d;

    logic             launch_hs;
    logic             cpl_hs;
    logic             cpl_cnt;
    logic             wdog_en;
    logic             wdog_clr;
    logic             wdog_expired;

    // Engine idle is status only; sequencing relies on the handshakes.
    logic             unused_ap_idle;
    assign unused_ap_idle = ap_idle;

    assign launch_hs = ap_start && ap_ready;
    assign cpl_hs    = ap_done && ap_continue;
    // A completion with nothing in flight is acknowledged but not counted.
    assign cpl_cnt   = cpl_hs && (outstanding_q != '0);

    // Clearing whenever not in RUN also covers the clear on entry to RUN.
    assign wdog_en  = (state_q == StRun) && (ap_start || (outstanding_q != '0));
    assign wdog_clr = (state_q != StRun) || launch_hs || cpl_hs;

    acc_wdog_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (WDOG_W)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wdog_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wdog_en),
        .expired  (wdog_expired)
    );

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        outstanding_d  = outstanding_q;
        launched_d     = launched_cnt;
        done_d         = done_cnt;
        run_complete_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    launched_d = '0;
                    done_d     = '0;
                    if (cmd_runs == '0) begin
                        run_complete_d = 1'b1;
                    end else begin
                        remaining_d = cmd_runs;
                        state_d     = StRun;
                    end
                end
            end

            StRun: begin
                if (launch_hs) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    launched_d  = launched_cnt + CNT_W'(1);
                end
                if (cpl_cnt) begin
                    done_d = done_cnt + CNT_W'(1);
                end
                case ({launch_hs, cpl_cnt})
                    2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                    2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
                    default: outstanding_d = outstanding_q;
                endcase
                // Finishing wins over a watchdog expiry in the same cycle.
                if ((remaining_d == '0) && (outstanding_d == '0)) begin
                    state_d        = StIdle;
                    run_complete_d = 1'b1;
                end else if (wdog_expired) begin
                    state_d = StErr;
                end
            end

            StErr: begin
                if (cpl_cnt) begin
                    outstanding_d = outstanding_q - OUT_W'(1);
                    done_d        = done_cnt + CNT_W'(1);
                end
                if (err_clear) begin
                    state_d       = StIdle;
                    remaining_d   = '0;
                    outstanding_d = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Computed from next-state values so the registered ap_start only
        // falls on the launch edge itself; it cannot drop while pending.
        ap_start_d = (state_d == StRun) && (remaining_d != '0) && (outstanding_d < MAX_OUT);

        // One acknowledge per done level; never issued from idle so a done
        // left over from before a reset waits for the next command.
        ap_continue_d = (state_d != StIdle) && ap_done && !ap_continue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            outstanding_q <= '0;
            launched_cnt  <= '0;
            done_cnt      <= '0;
            ap_start      <= 1'b0;
            ap_continue   <= 1'b0;
            run_complete  <= 1'b0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            cmd_ready     <= 1'b1;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            launched_cnt  <= launched_d;
            done_cnt      <= done_d;
            ap_start      <= ap_start_d;
            ap_continue   <= ap_continue_d;
            run_complete  <= run_complete_d;
            timeout_err   <= (state_d == StErr);
            busy          <= (state_d != StIdle);
            cmd_ready     <= (state_d == StIdle);
        end
    end

endmodule
